// File: rtl/axi_slave_mux_rd.sv
// ---------------------------------------------------------------------------
// axi_slave_mux_rd
//
// Read-path slave mux for one AXI master and two slaves. The master's AR
// request is routed to slave 0 or slave 1 by ARADDR[SEL_BIT]. The selected
// slave's R burst is steered back to the master. Only one read may be
// outstanding at a time. R beats are counted against the captured ARLEN, and
// any burst whose RLAST does not land on beat ARLEN sets a sticky len_err.
//
// Ports
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   s_AR*, s_RREADY          master-side request inputs
//   m_ARREADY, m_R*          master-side responses (muxed from selected slave)
//   s0_* / s1_*              per-slave AR valid/ready and R channel
//   busy                     high while a read is in ADDR or DATA
//   len_err                  sticky burst-length violation flag
// ---------------------------------------------------------------------------
module axi_slave_mux_rd #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int SEL_BIT    = 31
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // master side
  input  logic [ADDR_WIDTH-1:0] s_ARADDR,
  input  logic [7:0]            s_ARLEN,
  input  logic                  s_ARVALID,
  input  logic                  s_RREADY,
  output logic                  m_ARREADY,
  output logic [ID_WIDTH-1:0]   m_RID,
  output logic [DATA_WIDTH-1:0] m_RDATA,
  output logic [1:0]            m_RRESP,
  output logic                  m_RLAST,
  output logic [USER_WIDTH-1:0] m_RUSER,
  output logic                  m_RVALID,
  // slave 0
  output logic                  s0_ARVALID,
  input  logic                  s0_ARREADY,
  input  logic [ID_WIDTH-1:0]   s0_RID,
  input  logic [DATA_WIDTH-1:0] s0_RDATA,
  input  logic [1:0]            s0_RRESP,
  input  logic                  s0_RLAST,
  input  logic [USER_WIDTH-1:0] s0_RUSER,
  input  logic                  s0_RVALID,
  output logic                  s0_RREADY,
  // slave 1
  output logic                  s1_ARVALID,
  input  logic                  s1_ARREADY,
  input  logic [ID_WIDTH-1:0]   s1_RID,
  input  logic [DATA_WIDTH-1:0] s1_RDATA,
  input  logic [1:0]            s1_RRESP,
  input  logic                  s1_RLAST,
  input  logic [USER_WIDTH-1:0] s1_RUSER,
  input  logic                  s1_RVALID,
  output logic                  s1_RREADY,
  // status
  output logic                  busy,
  output logic                  len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       sel_reg, sel_next;
  logic [7:0] len_reg, len_next;
  logic [8:0] beat_reg, beat_next;
  logic       len_err_reg, len_err_next;

  // Slave-side signals gathered into arrays so the mux is a plain index
  // by sel_reg.
  logic [1:0]            ar_ready_arr;
  logic [1:0]            r_valid_arr;
  logic [1:0]            r_last_arr;
  logic [ID_WIDTH-1:0]   r_id_arr   [2];
  logic [DATA_WIDTH-1:0] r_data_arr [2];
  logic [1:0]            r_resp_arr [2];
  logic [USER_WIDTH-1:0] r_user_arr [2];
  logic [1:0]            ar_valid_arr;
  logic [1:0]            r_ready_arr;

  logic in_addr;
  logic in_data;
  logic r_beat;
  logic last_beat_idx;

  // Only ARADDR[SEL_BIT] affects routing; the remaining address bits are
  // folded here so they are not reported as dangling.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_ARADDR;

  assign ar_ready_arr  = {s1_ARREADY, s0_ARREADY};
  assign r_valid_arr   = {s1_RVALID, s0_RVALID};
  assign r_last_arr    = {s1_RLAST, s0_RLAST};
  assign r_id_arr[0]   = s0_RID;
  assign r_id_arr[1]   = s1_RID;
  assign r_data_arr[0] = s0_RDATA;
  assign r_data_arr[1] = s1_RDATA;
  assign r_resp_arr[0] = s0_RRESP;
  assign r_resp_arr[1] = s1_RRESP;
  assign r_user_arr[0] = s0_RUSER;
  assign r_user_arr[1] = s1_RUSER;

  assign in_addr = (state_reg == ADDR);
  assign in_data = (state_reg == DATA);

  // Per-slave request steering: only the selected slave ever sees ARVALID
  // or RREADY, so a stray RVALID from the other slave is never acknowledged.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slave
      assign ar_valid_arr[gi] = in_addr && (sel_reg == 1'(gi)) && s_ARVALID;
      assign r_ready_arr[gi]  = in_data && (sel_reg == 1'(gi)) && s_RREADY;
    end
  endgenerate

  assign s0_ARVALID = ar_valid_arr[0];
  assign s1_ARVALID = ar_valid_arr[1];
  assign s0_RREADY  = r_ready_arr[0];
  assign s1_RREADY  = r_ready_arr[1];

  // Master-side responses are forced to zero outside their phase.
  assign m_ARREADY = in_addr & ar_ready_arr[sel_reg];
  assign m_RVALID  = in_data & r_valid_arr[sel_reg];
  assign m_RLAST   = in_data & r_last_arr[sel_reg];
  assign m_RID     = in_data ? r_id_arr[sel_reg]   : '0;
  assign m_RDATA   = in_data ? r_data_arr[sel_reg] : '0;
  assign m_RRESP   = in_data ? r_resp_arr[sel_reg] : '0;
  assign m_RUSER   = in_data ? r_user_arr[sel_reg] : '0;

  assign busy    = (state_reg != IDLE);
  assign len_err = len_err_reg;

  assign r_beat        = m_RVALID & s_RREADY;
  assign last_beat_idx = (beat_reg == {1'b0, len_reg});

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    len_next     = len_reg;
    beat_next    = beat_reg;
    len_err_next = len_err_reg;

    case (state_reg)
      IDLE: begin
        // Request is only sampled here; the master holds ARADDR/ARLEN
        // stable until the AR handshake completes in ADDR.
        if (s_ARVALID) begin
          sel_next   = s_ARADDR[SEL_BIT];
          len_next   = s_ARLEN;
          beat_next  = '0;
          state_next = ADDR;
        end
      end

      ADDR: begin
        if (s_ARVALID && m_ARREADY) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (r_beat) begin
          beat_next = beat_reg + 9'd1;
          // RLAST must coincide with beat index ARLEN; either an early or a
          // missing RLAST is flagged, but the burst still ends on RLAST.
          if (m_RLAST && !last_beat_idx) begin
            len_err_next = 1'b1;
          end
          if (!m_RLAST && last_beat_idx) begin
            len_err_next = 1'b1;
          end
          if (m_RLAST) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg   <= IDLE;
      sel_reg     <= 1'b0;
      len_reg     <= 8'd0;
      beat_reg    <= 9'd0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      len_reg     <= len_next;
      beat_reg    <= beat_next;
      len_err_reg <= len_err_next;
    end
  end

endmodule

// File: tb/tb_axi_slave_mux_rd.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mux_rd
//
// Directed and randomized reads through axi_slave_mux_rd. The bench plays
// both slaves and the master. Expectations come from a transaction-level
// view: the slave is ARADDR[31], every beat the slave offers while the
// master is ready must appear unchanged on the master port, the other slave
// must never be touched, and len_err becomes set (and stays set until reset)
// as soon as any burst's beat count differs from ARLEN+1.
// ---------------------------------------------------------------------------
module tb_axi_slave_mux_rd;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int IW = 8;
  localparam int UW = 8;
  localparam int SB = 31;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [AW-1:0] s_ARADDR;
  logic [7:0]    s_ARLEN;
  logic          s_ARVALID;
  logic          s_RREADY;
  logic          m_ARREADY;
  logic [IW-1:0] m_RID;
  logic [DW-1:0] m_RDATA;
  logic [1:0]    m_RRESP;
  logic          m_RLAST;
  logic [UW-1:0] m_RUSER;
  logic          m_RVALID;
  logic          s0_ARVALID, s1_ARVALID;
  logic          s0_ARREADY, s1_ARREADY;
  logic [IW-1:0] s0_RID, s1_RID;
  logic [DW-1:0] s0_RDATA, s1_RDATA;
  logic [1:0]    s0_RRESP, s1_RRESP;
  logic          s0_RLAST, s1_RLAST;
  logic [UW-1:0] s0_RUSER, s1_RUSER;
  logic          s0_RVALID, s1_RVALID;
  logic          s0_RREADY, s1_RREADY;
  logic          busy;
  logic          len_err;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  bit exp_len_err = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_slave_mux_rd #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW), .SEL_BIT(SB)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARVALID(s_ARVALID), .s_RREADY(s_RREADY),
    .m_ARREADY(m_ARREADY), .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
    .m_RLAST(m_RLAST), .m_RUSER(m_RUSER), .m_RVALID(m_RVALID),
    .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY), .s0_RID(s0_RID), .s0_RDATA(s0_RDATA),
    .s0_RRESP(s0_RRESP), .s0_RLAST(s0_RLAST), .s0_RUSER(s0_RUSER), .s0_RVALID(s0_RVALID),
    .s0_RREADY(s0_RREADY),
    .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY), .s1_RID(s1_RID), .s1_RDATA(s1_RDATA),
    .s1_RRESP(s1_RRESP), .s1_RLAST(s1_RLAST), .s1_RUSER(s1_RUSER), .s1_RVALID(s1_RVALID),
    .s1_RREADY(s1_RREADY),
    .busy(busy), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic arvalid_of(input int n);
    return (n == 0) ? s0_ARVALID : s1_ARVALID;
  endfunction

  function automatic logic rready_of(input int n);
    return (n == 0) ? s0_RREADY : s1_RREADY;
  endfunction

  task automatic set_arready(input int n, input logic v);
    if (n == 0) s0_ARREADY = v;
    else        s1_ARREADY = v;
  endtask

  task automatic drive_r(input int n, input logic v, input logic [DW-1:0] d,
                         input logic [IW-1:0] id, input logic [1:0] rs,
                         input logic l, input logic [UW-1:0] u);
    if (n == 0) begin
      s0_RVALID = v; s0_RDATA = d; s0_RID = id; s0_RRESP = rs; s0_RLAST = l; s0_RUSER = u;
    end else begin
      s1_RVALID = v; s1_RDATA = d; s1_RID = id; s1_RRESP = rs; s1_RLAST = l; s1_RUSER = u;
    end
  endtask

  task automatic idle_inputs();
    s_ARVALID = 1'b0; s_ARADDR = '0; s_ARLEN = '0; s_RREADY = 1'b0;
    s0_ARREADY = 1'b0; s1_ARREADY = 1'b0;
    drive_r(0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    drive_r(1, 1'b0, '0, '0, 2'b00, 1'b0, '0);
  endtask

  // Every output, reset-state view.
  task automatic check_all_zero(input string tag);
    check({tag, "_arready"}, m_ARREADY, 0);
    check({tag, "_rvalid"},  m_RVALID, 0);
    check({tag, "_rdata"},   m_RDATA, 0);
    check({tag, "_rmisc"},   {m_RID, m_RRESP, m_RLAST, m_RUSER}, 0);
    check({tag, "_slv"},     {s0_ARVALID, s1_ARVALID, s0_RREADY, s1_RREADY}, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_lenerr"},  len_err, 0);
  endtask

  // One master read. rmode: 0 always ready, 1 random, 2 pattern 1,0,0,1.
  // vmode: 0 slave always valid, 1 random valid. stray: other slave emits
  // random RVALID. reset_at >= 0 pulses reset once that many beats moved.
  task automatic read_txn(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int nbeats, input int rmode, input int vmode,
                          input bit stray, input logic [1:0] resp, input int reset_at);
    int sel, oth, cyc, b, wait_ar;
    bit done;
    logic v, rr;
    logic [IW-1:0] rid;
    logic [UW-1:0] ruser;
    logic [DW-1:0] data_q[$];
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sel = int'(addr[SB]);
    oth = 1 - sel;
    rid = IW'($urandom);
    ruser = UW'($urandom);
    for (int i = 0; i < nbeats; i++) data_q.push_back({$urandom, $urandom});
    txn_no++;
    $display("txn %0d: addr=%h slave=%0d arlen=%0d beats=%0d rmode=%0d stray=%0d reset_at=%0d",
             txn_no, addr, sel, len, nbeats, rmode, stray, reset_at);

    // IDLE cycle: request is presented but not yet forwarded.
    @(negedge ACLK);
    s_ARADDR = addr; s_ARLEN = len; s_ARVALID = 1'b1;
    #1;
    check("idle_arvalid", {s0_ARVALID, s1_ARVALID}, 0);
    check("idle_busy", busy, 0);
    check("idle_arready", m_ARREADY, 0);

    // ADDR phase with a random slave ARREADY delay.
    wait_ar = $urandom_range(0, 2);
    cyc = 0; done = 1'b0;
    while (!done && cyc < 50) begin
      @(negedge ACLK);
      set_arready(sel, logic'(cyc >= wait_ar));
      #1;
      check("addr_arvalid_sel", arvalid_of(sel), 1);
      check("addr_arvalid_oth", arvalid_of(oth), 0);
      check("addr_busy", busy, 1);
      check("addr_arready", m_ARREADY, 64'(cyc >= wait_ar));
      check("addr_rvalid", m_RVALID, 0);
      if (cyc >= wait_ar) done = 1'b1;
      cyc++;
    end
    if (!done) check("ar_timeout", 0, 1);

    // DATA phase.
    b = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge ACLK);
      s_ARVALID = 1'b0;
      set_arready(sel, 1'b0);
      v  = (vmode == 0) ? 1'b1 : logic'($urandom_range(0, 1));
      if (rmode == 0)      rr = 1'b1;
      else if (rmode == 1) rr = logic'($urandom_range(0, 1));
      else                 rr = (cyc < 4) ? pat[cyc] : 1'b1;
      drive_r(sel, v, data_q[b], rid, resp, logic'(b == nbeats - 1), ruser);
      drive_r(oth, stray ? logic'($urandom_range(0, 1)) : 1'b0, {$urandom, $urandom},
              IW'($urandom), 2'($urandom), logic'($urandom_range(0, 1)), UW'($urandom));
      s_RREADY = rr;
      if (reset_at >= 0 && b == reset_at) begin
        ARESETn = 1'b0;
        exp_len_err = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge ACLK);
        idle_inputs();
        ARESETn = 1'b1;
        return;
      end
      #1;
      check("data_rvalid", m_RVALID, 64'(v));
      if (v) begin
        check("data_rdata", m_RDATA, data_q[b]);
        check("data_rid", m_RID, rid);
        check("data_rresp", m_RRESP, resp);
        check("data_ruser", m_RUSER, ruser);
        check("data_rlast", m_RLAST, 64'(b == nbeats - 1));
      end
      check("data_rready_sel", rready_of(sel), 64'(rr));
      check("data_rready_oth", rready_of(oth), 0);
      check("data_arvalid", {s0_ARVALID, s1_ARVALID, m_ARREADY}, 0);
      check("data_busy", busy, 1);
      if (v && rr) begin
        if (b == nbeats - 1) done = 1'b1;
        b++;
      end
      cyc++;
    end
    if (!done) check("r_timeout", 0, 1);

    // Model: any burst whose length differs from ARLEN+1 latches the error.
    if (nbeats != int'(len) + 1) exp_len_err = 1'b1;

    @(negedge ACLK);
    idle_inputs();
    #1;
    check("end_busy", busy, 0);
    check("end_rvalid", m_RVALID, 0);
    check("end_lenerr", len_err, 64'(exp_len_err));
  endtask

  initial begin
    int len, nb;
    logic [AW-1:0] a;
    idle_inputs();
    ARESETn = 1'b0;
    // Drive activity during reset: nothing may leak through.
    s_ARVALID = 1'b1; s0_RVALID = 1'b1; s1_RVALID = 1'b1; s_RREADY = 1'b1;
    s0_ARREADY = 1'b1; s1_ARREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    check_all_zero("reset");
    idle_inputs();
    @(negedge ACLK);
    ARESETn = 1'b1;

    read_txn(64'h0000_1000, 8'd3, 4, 0, 0, 1'b0, 2'b00, -1);   // s0, 4 beats
    read_txn(64'h8000_0000, 8'd0, 1, 0, 0, 1'b0, 2'b10, -1);   // s1, SLVERR beat
    read_txn(64'h0000_2000, 8'd1, 2, 2, 0, 1'b0, 2'b00, -1);   // RREADY 1,0,0,1
    read_txn(64'h0000_3000, 8'd3, 2, 0, 0, 1'b0, 2'b00, -1);   // early RLAST
    read_txn(64'h0000_4000, 8'd2, 3, 0, 0, 1'b0, 2'b01, -1);   // error stays set
    read_txn(64'h0000_5000, 8'd3, 4, 0, 0, 1'b1, 2'b00, -1);   // stray s1 RVALID
    read_txn(64'h0000_6000, 8'd3, 4, 0, 0, 1'b0, 2'b00, 1);    // reset on beat 2
    read_txn(64'h8000_1000, 8'd1, 2, 0, 0, 1'b0, 2'b00, -1);   // s1 after reset
    read_txn(64'h8000_2000, 8'd1, 3, 0, 0, 1'b0, 2'b00, -1);   // late RLAST

    for (int t = 0; t < 24; t++) begin
      a = {$urandom, $urandom};
      len = $urandom_range(0, 7);
      nb = len + 1;
      if ($urandom_range(0, 5) == 0) nb = $urandom_range(1, 9);
      read_txn(a, 8'(len), nb, 1, 1, 1'($urandom_range(0, 1)), 2'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_mux_rd.md
Name: axi_slave_mux_rd

Overview:
Read-path counterpart of the interconnect's write-side slave mux. It routes one master's AR request to one of two slaves using ARADDR[SEL_BIT], then steers that slave's R burst back to the master. It tracks the burst through an FSM and allows exactly one outstanding read. It counts R beats against ARLEN and flags burst-length violations.

Parameters:
DATA_WIDTH, 1024, R data width
ADDR_WIDTH, 64, AR address width
ID_WIDTH, 8, RID width
USER_WIDTH, 8, RUSER width
SEL_BIT, 31, address bit selecting the slave (0 -> s0, 1 -> s1); must be < ADDR_WIDTH

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; asynchronous, active-low
s_ARADDR  in  ADDR_WIDTH  master read address
s_ARLEN  in  8  master burst length (beats-1)
s_ARVALID  in  1  master AR valid
s_RREADY  in  1  master R ready
m_ARREADY  out  1  AR ready to master
m_RID  out  ID_WIDTH  muxed RID
m_RDATA  out  DATA_WIDTH  muxed RDATA
m_RRESP  out  2  muxed RRESP
m_RLAST  out  1  muxed RLAST
m_RUSER  out  USER_WIDTH  muxed RUSER
m_RVALID  out  1  muxed RVALID
s0_ARVALID / s1_ARVALID  out  1 each  AR valid to slave 0/1
s0_ARREADY / s1_ARREADY  in  1 each  AR ready from slave 0/1
s0_RID / s1_RID  in  ID_WIDTH each  slave RID
s0_RDATA / s1_RDATA  in  DATA_WIDTH each  slave RDATA
s0_RRESP / s1_RRESP  in  2 each  slave RRESP
s0_RLAST / s1_RLAST  in  1 each  slave RLAST
s0_RUSER / s1_RUSER  in  USER_WIDTH each  slave RUSER
s0_RVALID / s1_RVALID  in  1 each  slave RVALID
s0_RREADY / s1_RREADY  out  1 each  R ready to slave 0/1
busy  out  1  high in ADDR or DATA state
len_err  out  1  sticky burst-length violation flag

Behaviour:
- Registered state: FSM {IDLE, ADDR, DATA}, sel (1b), len (8b), beat (9b), len_err. Async reset: state=IDLE, sel=0, len=0, beat=0, len_err=0. All outputs are combinational from state. In reset/IDLE, every output is 0.
- IDLE: all slave ARVALID/RREADY=0, m_ARREADY=0, m_R*=0. When s_ARVALID=1, capture sel<=s_ARADDR[SEL_BIT], len<=s_ARLEN, beat<=0, and go to ADDR. The master holds ARADDR/ARLEN stable per AXI.
- ADDR: selected sN_ARVALID=s_ARVALID, other=0; m_ARREADY=selected sN_ARREADY. On s_ARVALID & m_ARREADY, go to DATA. Min AR latency is 1 cycle from s_ARVALID rise to sN_ARVALID.
- DATA: m_R* = selected slave's R signals; selected sN_RREADY=s_RREADY, other=0; m_ARREADY=0. Each beat (m_RVALID & s_RREADY) increments beat. On a beat with RLAST=1, go to IDLE.
- Length check, per beat in DATA:
  - RLAST=1 and beat!=len -> len_err<=1.
  - RLAST=0 and beat==len -> len_err<=1.
  - len_err clears only on reset.
  - The FSM still waits for RLAST.
- Non-selected slave's R inputs are ignored entirely. A stray RVALID from it is never forwarded or acknowledged.
- Single outstanding: a new AR is not accepted until the burst's RLAST handshake. Back-to-back reads incur a 1-cycle IDLE bubble.
- s_ARVALID deasserting in ADDR (protocol violation) -> remain in ADDR, with slave ARVALID following the input.
- RLAST handshake in the same cycle as a new s_ARVALID -> go to IDLE first. The new request is captured on the next cycle.
- Reset asserted mid-burst -> immediate IDLE, all outputs 0 asynchronously. Slaves are expected to be reset together.
- busy = (state!=IDLE).

Test Plan:
- ARADDR=0x0000_1000, ARLEN=3, s0 returns 4 beats D0..D3 with RLAST on beat 4 -> s0_ARVALID high 1 cycle after s_ARVALID; m_RDATA=D0..D3; s1_* outputs stay 0; busy drops after beat 4; len_err=0.
- ARADDR=0x8000_0000, ARLEN=0 -> s1 selected; single beat with RRESP=2'b10 forwarded; s0_ARVALID/s0_RREADY never assert.
- s_RREADY toggled 1,0,0,1 during a 2-beat burst from s0 -> beats transfer only when s_RREADY=1; beat count correct; no duplicated data.
- ARLEN=3, slave asserts RLAST on beat 2 -> len_err=1 and remains set through a following correct read.
- s1 asserts RVALID while s0 is selected -> m_RVALID reflects s0 only; s1_RREADY=0.
- ARESETn pulsed low during beat 2 of a 4-beat read -> all outputs 0 immediately; state IDLE; a new read to s1 after reset completes correctly.
